// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the ZBT memory arbiter: requester
// owner encoding, read-tag layout and the bank-address helper.
package mem_arbiter_pkg;

  localparam int ARB_LOG_ADDR = 19;

  // Owner encoding carried through the read pipe; NONE marks an idle cycle.
  typedef enum logic [1:0] {
    ARB_OWNER_VGA  = 2'd0,
    ARB_OWNER_NTSC = 2'd1,
    ARB_OWNER_PT   = 2'd2,
    ARB_OWNER_NONE = 2'd3
  } arb_owner_e;

  // Read tag is {valid, owner}.
  localparam int ARB_TAG_W = 3;

  // Builds a full address from a bank bit and an in-bank address.
  function automatic logic [ARB_LOG_ADDR-1:0] bank_addr(
    input logic                    bank,
    input logic [ARB_LOG_ADDR-2:0] low
  );
    return {bank, low};
  endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Read-tag shift register: carries {valid, owner} alongside the memory's
// fixed read pipeline so returning data can be steered to its requester.
module arb_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int D = 3,
  parameter int W = ARB_TAG_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] tag_in,
  output logic [W-1:0] tag_out
);

  logic [W-1:0] stage_r [D];

  // Shift tags one stage per cycle; reset discards everything in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < D; i++) begin
        stage_r[i] <= {W{1'b0}};
      end
    end else begin
      stage_r[0] <= tag_in;
      for (int i = 1; i < D; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign tag_out = stage_r[D-1];

endmodule

// File: rtl/mem_arbiter.sv
// ZBT memory arbiter: one pending slot per requester (VGA, NTSC, PT),
// VGA strict priority, NTSC/PT round-robin, one operation per cycle,
// tagged read returns, and the display/capture double-buffer bank bit.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LOG_ADDR     = 19,
  parameter int LOG_MEM      = 36,
  parameter int READ_LATENCY = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                frame_flag,
  input  logic                ntsc_frame_done,
  input  logic                vga_flag,
  input  logic [LOG_ADDR-2:0] vga_addr,
  output logic [LOG_MEM-1:0]  vga_pixel,
  output logic                done_vga,
  input  logic                ntsc_flag,
  input  logic [LOG_ADDR-2:0] ntsc_addr,
  input  logic [LOG_MEM-1:0]  ntsc_data,
  output logic                done_ntsc,
  input  logic                pt_flag,
  input  logic                pt_we,
  input  logic [LOG_ADDR-1:0] pt_addr,
  input  logic [LOG_MEM-1:0]  pt_wdata,
  output logic [LOG_MEM-1:0]  pt_rdata,
  output logic                done_pt,
  output logic                display_bank,
  output logic [LOG_ADDR-1:0] mem_addr,
  output logic                mem_we,
  output logic [LOG_MEM-1:0]  mem_wdata,
  input  logic [LOG_MEM-1:0]  mem_rdata,
  output logic                req_overrun
);

  // Pending slots
  logic                vga_pend_r;
  logic [LOG_ADDR-1:0] vga_slot_addr_r;
  logic                ntsc_pend_r;
  logic [LOG_ADDR-1:0] ntsc_slot_addr_r;
  logic [LOG_MEM-1:0]  ntsc_slot_data_r;
  logic                pt_pend_r;
  logic                pt_slot_we_r;
  logic [LOG_ADDR-1:0] pt_slot_addr_r;
  logic [LOG_MEM-1:0]  pt_slot_data_r;

  // Arbitration and bank state
  logic                rr_r;
  logic                capture_ready_r;
  logic                display_bank_r;
  logic                req_overrun_r;

  // Registered memory port and completion outputs
  logic [LOG_ADDR-1:0] mem_addr_r;
  logic                mem_we_r;
  logic [LOG_MEM-1:0]  mem_wdata_r;
  logic [LOG_MEM-1:0]  vga_pixel_r;
  logic [LOG_MEM-1:0]  pt_rdata_r;
  logic                done_vga_r;
  logic                done_ntsc_r;
  logic                done_pt_r;

  // Candidates: a full slot takes precedence over a same-cycle flag
  logic                vga_cand_s;
  logic [LOG_ADDR-1:0] vga_cand_addr_s;
  logic                ntsc_cand_s;
  logic [LOG_ADDR-1:0] ntsc_cand_addr_s;
  logic [LOG_MEM-1:0]  ntsc_cand_data_s;
  logic                pt_cand_s;
  logic                pt_cand_we_s;
  logic [LOG_ADDR-1:0] pt_cand_addr_s;
  logic [LOG_MEM-1:0]  pt_cand_data_s;

  logic                gnt_vga_s;
  logic                gnt_ntsc_s;
  logic                gnt_pt_s;
  arb_owner_e          issue_owner_s;
  logic                issue_valid_s;
  logic                issue_we_s;
  logic [LOG_ADDR-1:0] issue_addr_s;
  logic [LOG_MEM-1:0]  issue_wdata_s;

  logic [ARB_TAG_W-1:0] tag_in_s;
  logic [ARB_TAG_W-1:0] tag_out_s;
  logic                 tag_valid_s;
  arb_owner_e           tag_owner_s;
  logic                 vga_complete_s;
  logic                 pt_complete_s;
  logic                 swap_s;
  logic                 overrun_s;

  // The bank bit is bound when a request is first seen, so a request
  // pending across a swap keeps the bank it was issued against.
  assign vga_cand_s       = vga_pend_r | vga_flag;
  assign vga_cand_addr_s  = vga_pend_r ? vga_slot_addr_r
                                       : bank_addr(display_bank_r, vga_addr);
  assign ntsc_cand_s      = ntsc_pend_r | ntsc_flag;
  assign ntsc_cand_addr_s = ntsc_pend_r ? ntsc_slot_addr_r
                                        : bank_addr(~display_bank_r, ntsc_addr);
  assign ntsc_cand_data_s = ntsc_pend_r ? ntsc_slot_data_r : ntsc_data;
  assign pt_cand_s        = pt_pend_r | pt_flag;
  assign pt_cand_we_s     = pt_pend_r ? pt_slot_we_r   : pt_we;
  assign pt_cand_addr_s   = pt_pend_r ? pt_slot_addr_r : pt_addr;
  assign pt_cand_data_s   = pt_pend_r ? pt_slot_data_r : pt_wdata;

  assign overrun_s = (vga_flag  & vga_pend_r) |
                     (ntsc_flag & ntsc_pend_r) |
                     (pt_flag   & pt_pend_r);

  assign swap_s = frame_flag & (capture_ready_r | ntsc_frame_done);

  // Grant: VGA first, then NTSC/PT by round-robin pointer (rr_r=1 favours PT).
  always_comb begin
    gnt_vga_s     = 1'b0;
    gnt_ntsc_s    = 1'b0;
    gnt_pt_s      = 1'b0;
    issue_owner_s = ARB_OWNER_NONE;
    if (vga_cand_s) begin
      gnt_vga_s     = 1'b1;
      issue_owner_s = ARB_OWNER_VGA;
    end else if (ntsc_cand_s && pt_cand_s) begin
      if (rr_r) begin
        gnt_pt_s      = 1'b1;
        issue_owner_s = ARB_OWNER_PT;
      end else begin
        gnt_ntsc_s    = 1'b1;
        issue_owner_s = ARB_OWNER_NTSC;
      end
    end else if (ntsc_cand_s) begin
      gnt_ntsc_s    = 1'b1;
      issue_owner_s = ARB_OWNER_NTSC;
    end else if (pt_cand_s) begin
      gnt_pt_s      = 1'b1;
      issue_owner_s = ARB_OWNER_PT;
    end else begin
      issue_owner_s = ARB_OWNER_NONE;
    end
  end

  // Issue mux: select the winner's address, direction and write data.
  always_comb begin
    issue_valid_s = 1'b0;
    issue_we_s    = 1'b0;
    issue_addr_s  = {LOG_ADDR{1'b0}};
    issue_wdata_s = {LOG_MEM{1'b0}};
    case (issue_owner_s)
      ARB_OWNER_VGA: begin
        issue_valid_s = 1'b1;
        issue_addr_s  = vga_cand_addr_s;
      end
      ARB_OWNER_NTSC: begin
        issue_valid_s = 1'b1;
        issue_we_s    = 1'b1;
        issue_addr_s  = ntsc_cand_addr_s;
        issue_wdata_s = ntsc_cand_data_s;
      end
      ARB_OWNER_PT: begin
        issue_valid_s = 1'b1;
        issue_we_s    = pt_cand_we_s;
        issue_addr_s  = pt_cand_addr_s;
        issue_wdata_s = pt_cand_data_s;
      end
      default: begin
        issue_valid_s = 1'b0;
      end
    endcase
  end

  // VGA slot: cleared on grant, loaded by an ungranted flag into an empty slot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vga_pend_r      <= 1'b0;
      vga_slot_addr_r <= {LOG_ADDR{1'b0}};
    end else if (gnt_vga_s) begin
      vga_pend_r <= 1'b0;
    end else if (vga_flag && !vga_pend_r) begin
      vga_pend_r      <= 1'b1;
      vga_slot_addr_r <= vga_cand_addr_s;
    end
  end

  // NTSC slot: same load/clear rule; a flag into a full slot is dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ntsc_pend_r      <= 1'b0;
      ntsc_slot_addr_r <= {LOG_ADDR{1'b0}};
      ntsc_slot_data_r <= {LOG_MEM{1'b0}};
    end else if (gnt_ntsc_s) begin
      ntsc_pend_r <= 1'b0;
    end else if (ntsc_flag && !ntsc_pend_r) begin
      ntsc_pend_r      <= 1'b1;
      ntsc_slot_addr_r <= ntsc_cand_addr_s;
      ntsc_slot_data_r <= ntsc_cand_data_s;
    end
  end

  // PT slot: same load/clear rule, also capturing the request direction.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pt_pend_r      <= 1'b0;
      pt_slot_we_r   <= 1'b0;
      pt_slot_addr_r <= {LOG_ADDR{1'b0}};
      pt_slot_data_r <= {LOG_MEM{1'b0}};
    end else if (gnt_pt_s) begin
      pt_pend_r <= 1'b0;
    end else if (pt_flag && !pt_pend_r) begin
      pt_pend_r      <= 1'b1;
      pt_slot_we_r   <= pt_cand_we_s;
      pt_slot_addr_r <= pt_cand_addr_s;
      pt_slot_data_r <= pt_cand_data_s;
    end
  end

  // Round-robin pointer: after an NTSC grant favour PT, after PT favour NTSC.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_r <= 1'b0;
    end else if (gnt_ntsc_s) begin
      rr_r <= 1'b1;
    end else if (gnt_pt_s) begin
      rr_r <= 1'b0;
    end
  end

  // Double-buffer control: swap only at vblank once a capture frame is complete.
  always_ff @(posedge clock) begin
    if (!reset) begin
      display_bank_r  <= 1'b0;
      capture_ready_r <= 1'b0;
    end else if (swap_s) begin
      display_bank_r  <= ~display_bank_r;
      capture_ready_r <= 1'b0;
    end else if (ntsc_frame_done) begin
      capture_ready_r <= 1'b1;
    end
  end

  // Sticky overrun flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      req_overrun_r <= 1'b0;
    end else if (overrun_s) begin
      req_overrun_r <= 1'b1;
    end
  end

  // Memory port register: address and data hold when nothing is issued.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_addr_r  <= {LOG_ADDR{1'b0}};
      mem_we_r    <= 1'b0;
      mem_wdata_r <= {LOG_MEM{1'b0}};
    end else if (issue_valid_s) begin
      mem_addr_r  <= issue_addr_s;
      mem_we_r    <= issue_we_s;
      mem_wdata_r <= issue_wdata_s;
    end else begin
      mem_we_r <= 1'b0;
    end
  end

  // Only reads are tagged; writes complete at issue.
  assign tag_in_s = {issue_valid_s & ~issue_we_s, issue_owner_s};

  arb_tag_pipe #(
    .D (READ_LATENCY + 1),
    .W (ARB_TAG_W)
  ) u_tag_pipe (
    .clock   (clock),
    .reset   (reset),
    .tag_in  (tag_in_s),
    .tag_out (tag_out_s)
  );

  assign tag_valid_s    = tag_out_s[ARB_TAG_W-1];
  assign tag_owner_s    = arb_owner_e'(tag_out_s[1:0]);
  assign vga_complete_s = tag_valid_s && (tag_owner_s == ARB_OWNER_VGA);
  assign pt_complete_s  = tag_valid_s && (tag_owner_s == ARB_OWNER_PT);

  // Completion: capture returning read data and pulse the owner's done.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vga_pixel_r <= {LOG_MEM{1'b0}};
      pt_rdata_r  <= {LOG_MEM{1'b0}};
      done_vga_r  <= 1'b0;
      done_ntsc_r <= 1'b0;
      done_pt_r   <= 1'b0;
    end else begin
      done_vga_r  <= vga_complete_s;
      done_ntsc_r <= gnt_ntsc_s;
      done_pt_r   <= (gnt_pt_s && pt_cand_we_s) || pt_complete_s;
      if (vga_complete_s) begin
        vga_pixel_r <= mem_rdata;
      end
      if (pt_complete_s) begin
        pt_rdata_r <= mem_rdata;
      end
    end
  end

  assign vga_pixel    = vga_pixel_r;
  assign pt_rdata     = pt_rdata_r;
  assign done_vga     = done_vga_r;
  assign done_ntsc    = done_ntsc_r;
  assign done_pt      = done_pt_r;
  assign display_bank = display_bank_r;
  assign mem_addr     = mem_addr_r;
  assign mem_we       = mem_we_r;
  assign mem_wdata    = mem_wdata_r;
  assign req_overrun  = req_overrun_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model posts expected
// issues, completions and status per cycle; a negedge monitor checks them.
module tb_mem_arbiter;

  localparam int LOG_ADDR = 19;
  localparam int LOG_MEM  = 36;
  localparam int RL       = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                reset;
  logic                frame_flag, ntsc_frame_done;
  logic                vga_flag;
  logic [LOG_ADDR-2:0] vga_addr;
  logic [LOG_MEM-1:0]  vga_pixel;
  logic                done_vga;
  logic                ntsc_flag;
  logic [LOG_ADDR-2:0] ntsc_addr;
  logic [LOG_MEM-1:0]  ntsc_data;
  logic                done_ntsc;
  logic                pt_flag, pt_we;
  logic [LOG_ADDR-1:0] pt_addr;
  logic [LOG_MEM-1:0]  pt_wdata;
  logic [LOG_MEM-1:0]  pt_rdata;
  logic                done_pt;
  logic                display_bank;
  logic [LOG_ADDR-1:0] mem_addr;
  logic                mem_we;
  logic [LOG_MEM-1:0]  mem_wdata;
  logic [LOG_MEM-1:0]  mem_rdata;
  logic                req_overrun;

  mem_arbiter #(.LOG_ADDR(LOG_ADDR), .LOG_MEM(LOG_MEM), .READ_LATENCY(RL)) dut (
    .clock(clock), .reset(reset), .frame_flag(frame_flag),
    .ntsc_frame_done(ntsc_frame_done), .vga_flag(vga_flag), .vga_addr(vga_addr),
    .vga_pixel(vga_pixel), .done_vga(done_vga), .ntsc_flag(ntsc_flag),
    .ntsc_addr(ntsc_addr), .ntsc_data(ntsc_data), .done_ntsc(done_ntsc),
    .pt_flag(pt_flag), .pt_we(pt_we), .pt_addr(pt_addr), .pt_wdata(pt_wdata),
    .pt_rdata(pt_rdata), .done_pt(done_pt), .display_bank(display_bank),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .req_overrun(req_overrun)
  );

  // Memory contents are a fixed function of the address (writes not stored).
  function automatic logic [LOG_MEM-1:0] mem_f(input logic [LOG_ADDR-1:0] a);
    if (a == 19'h00100) return 36'h000000ABC;
    return {a[16:0], a} ^ 36'h95A5A5A5A;
  endfunction

  logic [LOG_MEM-1:0] rd_s1;
  // ZBT read pipeline: address in cycle c, data in cycle c+2.
  always @(posedge clock) begin
    rd_s1     <= mem_f(mem_addr);
    mem_rdata <= rd_s1;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    int                  c;
    logic [LOG_ADDR-1:0] addr;
    logic                we;
    logic [LOG_MEM-1:0]  data;
  } ev_t;
  typedef struct { int c; logic bank; logic ovr; } st_t;
  typedef struct {
    logic                we;
    logic [LOG_ADDR-1:0] addr;
    logic [LOG_MEM-1:0]  data;
  } req_t;

  ev_t iss_q[$], vga_q[$], ntsc_q[$], ptw_q[$], ptr_q[$];
  st_t st_q[$];
  int  rst_q[$];

  // Reference model state: one slot per requester (0 VGA, 1 NTSC, 2 PT).
  req_t slot_m [3];
  bit   full_m [3];
  bit   rr_m, bank_m, cap_m, ovr_m;

  // Advance the model by one cycle using the inputs currently driven.
  task automatic model_step();
    int   c;
    int   win;
    req_t inc  [3];
    req_t cand [3];
    bit   fl   [3];
    bit   has  [3];
    c = cyc;
    if (!reset) begin
      for (int i = 0; i < 3; i++) full_m[i] = 1'b0;
      rr_m = 1'b0; bank_m = 1'b0; cap_m = 1'b0; ovr_m = 1'b0;
      while (iss_q.size() > 0 && iss_q[$].c > c)   void'(iss_q.pop_back());
      while (vga_q.size() > 0 && vga_q[$].c > c)   void'(vga_q.pop_back());
      while (ntsc_q.size() > 0 && ntsc_q[$].c > c) void'(ntsc_q.pop_back());
      while (ptw_q.size() > 0 && ptw_q[$].c > c)   void'(ptw_q.pop_back());
      while (ptr_q.size() > 0 && ptr_q[$].c > c)   void'(ptr_q.pop_back());
      while (st_q.size() > 0 && st_q[$].c > c)     void'(st_q.pop_back());
      rst_q.push_back(c + 1);
      st_q.push_back('{c + 1, 1'b0, 1'b0});
      return;
    end
    fl[0] = vga_flag;  inc[0] = '{1'b0, {bank_m, vga_addr}, 36'h0};
    fl[1] = ntsc_flag; inc[1] = '{1'b1, {~bank_m, ntsc_addr}, ntsc_data};
    fl[2] = pt_flag;   inc[2] = '{pt_we, pt_addr, pt_wdata};
    for (int i = 0; i < 3; i++) begin
      has[i]  = full_m[i] || fl[i];
      cand[i] = full_m[i] ? slot_m[i] : inc[i];
      if (fl[i] && full_m[i]) ovr_m = 1'b1;
    end
    win = -1;
    if (has[0])                 win = 0;
    else if (has[1] && has[2])  win = rr_m ? 2 : 1;
    else if (has[1])            win = 1;
    else if (has[2])            win = 2;
    if (win == 1) rr_m = 1'b1;
    if (win == 2) rr_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == win) full_m[i] = 1'b0;
      else if (fl[i] && !full_m[i]) begin
        full_m[i] = 1'b1;
        slot_m[i] = inc[i];
      end
    end
    if (win >= 0) begin
      iss_q.push_back('{c + 1, cand[win].addr, cand[win].we, cand[win].data});
      if (cand[win].we) begin
        if (win == 1) ntsc_q.push_back('{c + 1, cand[win].addr, 1'b1, cand[win].data});
        else          ptw_q.push_back('{c + 1, cand[win].addr, 1'b1, cand[win].data});
      end else begin
        if (win == 0) vga_q.push_back('{c + 2 + RL, cand[win].addr, 1'b0, mem_f(cand[win].addr)});
        else          ptr_q.push_back('{c + 2 + RL, cand[win].addr, 1'b0, mem_f(cand[win].addr)});
      end
    end
    if (frame_flag && (cap_m || ntsc_frame_done)) begin
      bank_m = ~bank_m;
      cap_m  = 1'b0;
    end else if (ntsc_frame_done) begin
      cap_m = 1'b1;
    end
    st_q.push_back('{c + 1, bank_m, ovr_m});
  endtask

  // Monitor: compare DUT outputs against whatever the model posted for this cycle.
  logic [LOG_MEM-1:0]  last_vga, last_pt;
  logic [LOG_ADDR-1:0] last_addr;
  ev_t me;
  st_t ms;
  bit  hit_w, hit_r;
  always @(negedge clock) begin
    if (cyc >= 1) begin
      if (rst_q.size() > 0 && rst_q[0] == cyc) begin
        void'(rst_q.pop_front());
        chk("rst_vga_pixel", vga_pixel, 0);
        chk("rst_pt_rdata", pt_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        last_vga = '0; last_pt = '0; last_addr = '0;
      end
      if (st_q.size() > 0 && st_q[0].c == cyc) begin
        ms = st_q.pop_front();
        chk("display_bank", display_bank, ms.bank);
        chk("req_overrun", req_overrun, ms.ovr);
      end
      if (iss_q.size() > 0 && iss_q[0].c == cyc) begin
        me = iss_q.pop_front();
        chk("mem_we", mem_we, me.we);
        chk("mem_addr", mem_addr, me.addr);
        if (me.we) chk("mem_wdata", mem_wdata, me.data);
        last_addr = me.addr;
      end else begin
        chk("mem_we_idle", mem_we, 0);
        chk("mem_addr_hold", mem_addr, last_addr);
      end
      if (vga_q.size() > 0 && vga_q[0].c == cyc) begin
        me = vga_q.pop_front();
        chk("done_vga", done_vga, 1);
        last_vga = me.data;
      end else begin
        chk("done_vga_idle", done_vga, 0);
      end
      chk("vga_pixel", vga_pixel, last_vga);
      if (ntsc_q.size() > 0 && ntsc_q[0].c == cyc) begin
        void'(ntsc_q.pop_front());
        chk("done_ntsc", done_ntsc, 1);
      end else begin
        chk("done_ntsc_idle", done_ntsc, 0);
      end
      hit_w = 1'b0; hit_r = 1'b0;
      if (ptw_q.size() > 0 && ptw_q[0].c == cyc) begin
        void'(ptw_q.pop_front());
        hit_w = 1'b1;
      end
      if (ptr_q.size() > 0 && ptr_q[0].c == cyc) begin
        me = ptr_q.pop_front();
        hit_r = 1'b1;
        last_pt = me.data;
      end
      chk("done_pt", done_pt, hit_w | hit_r);
      chk("pt_rdata", pt_rdata, last_pt);
    end
  end

  task automatic clear_inputs();
    reset = 1'b1; frame_flag = 1'b0; ntsc_frame_done = 1'b0;
    vga_flag = 1'b0; ntsc_flag = 1'b0; pt_flag = 1'b0; pt_we = 1'b0;
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    vga_addr = '0; ntsc_addr = '0; ntsc_data = '0; pt_addr = '0; pt_wdata = '0;
    last_vga = '0; last_pt = '0; last_addr = '0;
    clear_inputs();
    repeat (3) begin reset = 1'b0; step(); end
    idle(2);

    // Uncontested VGA read from bank 0
    vga_flag = 1'b1; vga_addr = 18'h00100; step();
    idle(6);

    // All three at once: VGA, then NTSC, then PT
    vga_flag = 1'b1; vga_addr = 18'h00222;
    ntsc_flag = 1'b1; ntsc_addr = 18'h01234; ntsc_data = 36'h111111111;
    pt_flag = 1'b1; pt_we = 1'b0; pt_addr = 19'h45678;
    step();
    idle(6);

    // Repeated NTSC+PT pairs, mixed PT direction
    for (int k = 0; k < 4; k++) begin
      ntsc_flag = 1'b1; ntsc_addr = 18'($urandom); ntsc_data = {4'h0, 32'($urandom)};
      pt_flag = 1'b1; pt_we = k[0]; pt_addr = 19'($urandom); pt_wdata = {4'hA, 32'($urandom)};
      step();
    end
    idle(6);

    // Bank swap after a completed capture frame, then a swap-less vblank
    ntsc_frame_done = 1'b1; step();
    idle(2);
    frame_flag = 1'b1; step();
    ntsc_flag = 1'b1; ntsc_addr = 18'h00ABC; ntsc_data = 36'h222222222; step();
    idle(3);
    frame_flag = 1'b1; step();
    idle(3);

    // PT overrun while VGA saturates the port
    for (int k = 0; k < 5; k++) begin
      vga_flag = 1'b1; vga_addr = 18'(k);
      if (k == 0) begin pt_flag = 1'b1; pt_we = 1'b0; pt_addr = 19'h12345; end
      if (k == 2) begin pt_flag = 1'b1; pt_we = 1'b0; pt_addr = 19'h54321; end
      step();
    end
    idle(6);

    // Reset one cycle after a VGA read issues; then a fresh read
    vga_flag = 1'b1; vga_addr = 18'h03333; step();
    reset = 1'b0; step();
    idle(6);
    vga_flag = 1'b1; vga_addr = 18'h00100; step();
    idle(6);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      vga_flag        = ($urandom_range(0, 3) == 0);
      vga_addr        = 18'($urandom);
      ntsc_flag       = ($urandom_range(0, 2) == 0);
      ntsc_addr       = 18'($urandom);
      ntsc_data       = {4'($urandom), 32'($urandom)};
      pt_flag         = ($urandom_range(0, 2) == 0);
      pt_we           = 1'($urandom);
      pt_addr         = 19'($urandom);
      pt_wdata        = {4'($urandom), 32'($urandom)};
      frame_flag      = ($urandom_range(0, 39) == 0);
      ntsc_frame_done = ($urandom_range(0, 29) == 0);
      reset           = ($urandom_range(0, 149) != 0);
      step();
    end
    idle(10);

    chk("drain_pending", iss_q.size() + vga_q.size() + ntsc_q.size()
                         + ptw_q.size() + ptr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
